inst_sequencer: RTL

Fetch-and-step sequencer sitting directly upstream of the control unit. It fetches 9-bit instruction words from instruction memory into an instruction register (IR). For mvi it also fetches the trailing immediate word. It drives ctrlu_inst and ctrlu_step to the control unit and advances the step counter and PC based on ctrlu_instDone returned from it. Opcode field is IR[8:6]: 000 mv, 001 mvi, 010–111 ALU ops.

---
 rtl/inst_sequencer_if.sv | 28 ++
 rtl/inst_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/inst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_sequencer_if
// Brief    : Instruction-memory read port and control-unit step port.
// Revision : 1.0
// ============================================================================
interface inst_sequencer_if #(
    parameter int INST_W = 9,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] ctrlu_inst;
    logic [1:0]        ctrlu_step;
    logic              ctrlu_instDone;

    modport master (
        output imem_addr, imem_rd, ctrlu_inst, ctrlu_step,
        input  imem_data, ctrlu_instDone
    );

    modport slave (
        input  imem_addr, imem_rd, ctrlu_inst, ctrlu_step,
        output imem_data, ctrlu_instDone
    );
endinterface
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inst_sequencer
// Brief    : Fetches instructions (plus mvi immediate) and steps the control unit.
// Revision : 1.0
// ============================================================================
module inst_sequencer #(
    parameter int INST_W = 9,
    parameter int ADDR_W = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        run,
    inst_sequencer_if.master bus,
    output logic              exec_en,
    output logic [INST_W-1:0] imm_data,
    output logic [ADDR_W-1:0] pc,
    output logic              seq_busy,
    output logic              seq_err
);
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_LATCH = 3'd2;
    localparam logic [2:0] c_IMM   = 3'd3;
    localparam logic [2:0] c_EXEC  = 3'd4;
    localparam logic [2:0] c_ERR   = 3'd5;

    localparam logic [2:0] c_OP_MVI = 3'b001;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_ir;
    logic [1:0]        r_step;
    logic [INST_W-1:0] r_imm;

    logic              w_fetch_mvi;
    logic              w_ir_mvi;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_adv;

    // Opcode seen on the data bus in LATCH decides whether the immediate is read.
    assign w_fetch_mvi = (bus.imem_data[INST_W-1 -: 3] == c_OP_MVI);
    assign w_ir_mvi    = (r_ir[INST_W-1 -: 3] == c_OP_MVI);
    assign w_pc_plus1  = r_pc + ADDR_W'(1);
    assign w_pc_adv    = r_pc + (w_ir_mvi ? ADDR_W'(2) : ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (run) w_next_state = c_FETCH;
            c_FETCH: w_next_state = c_LATCH;
            c_LATCH: w_next_state = w_fetch_mvi ? c_IMM : c_EXEC;
            c_IMM:   w_next_state = c_EXEC;
            c_EXEC: begin
                if (bus.ctrlu_instDone) begin
                    w_next_state = run ? c_FETCH : c_IDLE;
                end else if (r_step == 2'd3) begin
                    w_next_state = c_ERR;
                end
            end
            c_ERR:   w_next_state = c_ERR;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_step <= '0;
            r_imm  <= '0;
        end else begin
            case (r_state)
                c_LATCH: r_ir  <= bus.imem_data;
                c_IMM:   r_imm <= bus.imem_data;
                c_EXEC: begin
                    if (bus.ctrlu_instDone) begin
                        r_step <= '0;
                        r_pc   <= w_pc_adv;
                    end else if (r_step != 2'd3) begin
                        r_step <= r_step + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.imem_rd   = 1'b0;
        bus.imem_addr = '0;
        exec_en       = 1'b0;
        seq_err       = 1'b0;
        seq_busy      = (r_state != c_IDLE) && (r_state != c_ERR);
        case (r_state)
            c_FETCH: begin
                bus.imem_rd   = 1'b1;
                bus.imem_addr = r_pc;
            end
            c_LATCH: begin
                if (w_fetch_mvi) begin
                    bus.imem_rd   = 1'b1;
                    bus.imem_addr = w_pc_plus1;
                end
            end
            c_EXEC:  exec_en = 1'b1;
            c_ERR:   seq_err = 1'b1;
            default: ;
        endcase
    end

    assign bus.ctrlu_inst = r_ir;
    assign bus.ctrlu_step = r_step;
    assign imm_data       = r_imm;
    assign pc             = r_pc;
endmodule
`default_nettype wire
